// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control-side partner of the 3-bit load/enable/up-down drink-timing
//   counter. It latches a brew preset chosen by sel, loads it into the
//   counter, issues one count-down enable per prescaled tick, and pulses
//   done when the brew completes. Abort reloads the counter with 0 and
//   returns to idle without a done pulse. Pause freezes the prescaler and
//   closes the valve until it is released.
//
// Ports
//   Counter_clock      in   system clock, rising edge
//   Counter_rst_n      in   asynchronous active-low reset
//   start              in   brew request (level, only acted on in IDLE)
//   abort              in   cancel current brew (highest priority)
//   pause              in   hold timing while high
//   sel[1:0]           in   drink select, 2'b11 reserved
//   Counter_LD         out  counter load strobe
//   Counter_EN         out  counter count enable
//   Counter_UD         out  counter direction, 1 = down
//   Counter_pre_value  out  value loaded while Counter_LD=1
//   Counter_cnt_value  in   current counter value
//   busy               out  sequencer not idle
//   valve_on           out  brew valve drive
//   done               out  one-cycle completion pulse
//   err                out  one-cycle pulse on start with sel=11
module counter_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int PRESET0  = 3,
  parameter int PRESET1  = 5,
  parameter int PRESET2  = 7
) (
  input  logic       Counter_clock,
  input  logic       Counter_rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [1:0] sel,
  output logic       Counter_LD,
  output logic       Counter_EN,
  output logic       Counter_UD,
  output logic [2:0] Counter_pre_value,
  input  logic [2:0] Counter_cnt_value,
  output logic       busy,
  output logic       valve_on,
  output logic       done,
  output logic       err
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]      P0        = 3'(PRESET0);
  localparam logic [2:0]      P1        = 3'(PRESET1);
  localparam logic [2:0]      P2        = 3'(PRESET2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_HOLD, S_CLEAR, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    preset_q, preset_d;
  logic          err_q, err_d;
  logic          tick;

  assign tick = (presc_q == TICK_LAST);

  always_ff @(posedge Counter_clock or negedge Counter_rst_n) begin
    if (!Counter_rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      preset_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      preset_q <= preset_d;
      err_q    <= err_d;
    end
  end

  // Next state. abort > pause > start/tick on every edge.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (!abort && start) begin
          if (sel == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            unique case (sel)
              2'b00:   preset_d = P0;
              2'b01:   preset_d = P1;
              default: preset_d = P2;
            endcase
          end
        end
      end
      S_LOAD: begin
        presc_d = '0;
        state_d = abort ? S_CLEAR : S_RUN;
      end
      S_RUN: begin
        // The RUN cycle is always consumed, even on the edge that enters
        // HOLD; otherwise a pause landing on a tick cycle would replay that
        // tick after resume and decrement twice.
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (abort)
          state_d = S_CLEAR;
        else if (pause)
          state_d = S_HOLD;
        // The enable issued while the count reads 1 empties the counter,
        // so finish on that edge rather than one cycle later.
        else if (Counter_cnt_value == 3'd0 ||
                 (tick && Counter_cnt_value == 3'd1))
          state_d = S_DONE;
      end
      S_HOLD: begin
        if (abort)
          state_d = S_CLEAR;
        else if (!pause)
          state_d = S_RUN;
      end
      S_CLEAR: begin
        presc_d = '0;
        state_d = S_IDLE;
      end
      S_DONE: begin
        presc_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        presc_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state/prescaler only; Counter_EN also
  // looks at the live count so it never underflows the counter.
  always_comb begin
    Counter_LD        = 1'b0;
    Counter_EN        = 1'b0;
    Counter_UD        = 1'b0;
    Counter_pre_value = 3'd0;
    valve_on          = 1'b0;
    done              = 1'b0;
    busy              = (state_q != S_IDLE);
    err               = err_q;
    unique case (state_q)
      S_LOAD: begin
        Counter_LD        = 1'b1;
        Counter_pre_value = preset_q;
      end
      S_RUN: begin
        Counter_UD = 1'b1;
        valve_on   = 1'b1;
        Counter_EN = tick && (Counter_cnt_value != 3'd0);
      end
      S_HOLD:  Counter_UD = 1'b1;
      S_CLEAR: Counter_LD = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       Counter_clock = 1'b0;
  logic       Counter_rst_n;
  logic       start, abort, pause;
  logic [1:0] sel;
  logic       Counter_LD, Counter_EN, Counter_UD;
  logic [2:0] Counter_pre_value, Counter_cnt_value;
  logic       busy, valve_on, done, err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Counter_clock = ~Counter_clock;

  counter_sequencer #(.TICK_DIV(4)) dut (
    .Counter_clock    (Counter_clock),
    .Counter_rst_n    (Counter_rst_n),
    .start            (start),
    .abort            (abort),
    .pause            (pause),
    .sel              (sel),
    .Counter_LD       (Counter_LD),
    .Counter_EN       (Counter_EN),
    .Counter_UD       (Counter_UD),
    .Counter_pre_value(Counter_pre_value),
    .Counter_cnt_value(Counter_cnt_value),
    .busy             (busy),
    .valve_on         (valve_on),
    .done             (done),
    .err              (err)
  );

  // Behavioural model of the 3-bit load/enable/up-down counter being driven.
  always @(posedge Counter_clock or negedge Counter_rst_n) begin
    if (!Counter_rst_n)  Counter_cnt_value <= 3'd0;
    else if (Counter_LD) Counter_cnt_value <= Counter_pre_value;
    else if (Counter_EN) Counter_cnt_value <= Counter_UD ? Counter_cnt_value - 3'd1
                                                         : Counter_cnt_value + 3'd1;
  end

  // {LD, EN, UD, pre[2:0], busy, valve, done, err, cnt[2:0]}
  logic [12:0] outs;
  assign outs = {Counter_LD, Counter_EN, Counter_UD, Counter_pre_value,
                 busy, valve_on, done, err, Counter_cnt_value};

  typedef struct {
    logic       st, ab, pa;
    logic [1:0] sel;
    logic [12:0] exp;
  } vec_t;

  function automatic vec_t mk(logic st, logic ab, logic pa, logic [1:0] s,
                              logic ld, logic en, logic ud, logic [2:0] pre,
                              logic bz, logic vl, logic dn, logic er,
                              logic [2:0] cnt);
    vec_t v;
    v.st = st; v.ab = ab; v.pa = pa; v.sel = s;
    v.exp = {ld, en, ud, pre, bz, vl, dn, er, cnt};
    return v;
  endfunction

  task automatic check(input string nm, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  // Runs one brew from the current negedge (cycle 0 = start sampled at the
  // next edge). pause is sampled high on edges pa..pa+pl-1. Returns at the
  // negedge of the first idle cycle after done (or after a cycle budget).
  task automatic measure(input logic [1:0] s, input int pa, input int pl,
                         output int done_cyc, output int en_cnt,
                         output int done_n, output int bad_hold);
    done_cyc = -1; en_cnt = 0; done_n = 0; bad_hold = 0;
    start = 1'b1; sel = s;
    for (int k = 1; k <= 80; k++) begin
      @(negedge Counter_clock);
      start = 1'b0;
      if (Counter_EN) en_cnt++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k > pa && k <= pa + pl &&
          !(Counter_EN == 1'b0 && valve_on == 1'b0 && Counter_UD == 1'b1 && busy == 1'b1))
        bad_hold++;
      pause = (k >= pa && k < pa + pl);
      if (done_cyc >= 0 && k >= done_cyc + 1) break;
    end
    pause = 1'b0;
  endtask

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, en, dn, bh;
    // sel=00 brew, P=3, TICK_DIV=4; start re-asserted mid-RUN must be ignored.
    //              st ab pa sel  ld en ud pre  bz vl dn er cnt
    tbl[0]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
    tbl[1]  = mk(0, 0, 0, 2'd0, 1, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0);
    tbl[2]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd3);
    tbl[3]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd3);
    tbl[4]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd3);
    tbl[5]  = mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 1, 1, 0, 0, 3'd3);
    tbl[6]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd2);
    tbl[7]  = mk(1, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd2);
    tbl[8]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd2);
    tbl[9]  = mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 1, 1, 0, 0, 3'd2);
    tbl[10] = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd1);
    tbl[11] = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd1);
    tbl[12] = mk(0, 0, 0, 2'd0, 0, 0, 1, 3'd0, 1, 1, 0, 0, 3'd1);
    tbl[13] = mk(0, 0, 0, 2'd0, 0, 1, 1, 3'd0, 1, 1, 0, 0, 3'd1);
    tbl[14] = mk(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 1, 0, 1, 0, 3'd0);
    tbl[15] = mk(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);

    Counter_rst_n = 1'b1;
    start = 1'b0; abort = 1'b0; pause = 1'b0; sel = 2'd0;
    #2 Counter_rst_n = 1'b0;
    @(negedge Counter_clock);
    check("reset_state", 0, 32'(outs), 32'h0);
    @(negedge Counter_clock);
    Counter_rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      check("brew_sel0", i, 32'(outs), 32'(tbl[i].exp));
      start = tbl[i].st; abort = tbl[i].ab; pause = tbl[i].pa; sel = tbl[i].sel;
      @(negedge Counter_clock);
    end

    // Reserved select: one-cycle err, no load, stays idle.
    start = 1'b1; sel = 2'd3;
    @(negedge Counter_clock);
    check("err_pulse", 0, {29'd0, err, busy, Counter_LD}, 32'b100);
    start = 1'b0;
    @(negedge Counter_clock);
    check("err_pulse", 1, {29'd0, err, busy, Counter_LD}, 32'b000);

    // start with abort in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1; sel = 2'd0;
    @(negedge Counter_clock);
    check("start_abort_idle", 0, {29'd0, busy, Counter_LD, err}, 32'b000);
    start = 1'b0; abort = 1'b0;
    @(negedge Counter_clock);

    // Abort two cycles after LOAD (sel=01).
    start = 1'b1; sel = 2'd1;
    @(negedge Counter_clock);
    check("abort_load", 1, {28'd0, Counter_LD, Counter_pre_value}, {28'd0, 1'b1, 3'd5});
    start = 1'b0;
    @(negedge Counter_clock);
    @(negedge Counter_clock);
    abort = 1'b1;
    @(negedge Counter_clock);
    check("abort_clear", 4, {26'd0, Counter_LD, Counter_pre_value, busy, done},
          {26'd0, 1'b1, 3'd0, 1'b1, 1'b0});
    abort = 1'b0;
    @(negedge Counter_clock);
    check("abort_idle", 5, {26'd0, busy, Counter_LD, done, Counter_cnt_value}, 32'h0);
    dn = 0;
    repeat (8) begin
      @(negedge Counter_clock);
      if (done) dn++;
    end
    check("abort_no_done", 0, 32'(dn), 32'd0);

    // Unpaused sel=10 and sel=01 brews: done at cycle 2 + P*4.
    measure(2'd2, 0, 0, d, en, dn, bh);
    check("sel2_done_cycle", 0, 32'(d), 32'd30);
    check("sel2_en_count", 0, 32'(en), 32'd7);
    measure(2'd1, 0, 0, d, en, dn, bh);
    check("sel1_done_cycle", 0, 32'(d), 32'd22);
    check("sel1_done_width", 0, 32'(dn), 32'd1);

    // sel=10 with pause high for 6 edges mid-RUN: done shifts by exactly 6.
    measure(2'd2, 10, 6, d, en, dn, bh);
    check("pause_done_cycle", 0, 32'(d), 32'd36);
    check("pause_en_count", 0, 32'(en), 32'd7);
    check("pause_hold_outputs", 0, 32'(bh), 32'd0);
    check("pause_done_width", 0, 32'(dn), 32'd1);

    // Asynchronous reset mid-RUN, then a fresh full-length brew.
    start = 1'b1; sel = 2'd0;
    @(negedge Counter_clock);
    start = 1'b0;
    repeat (5) @(negedge Counter_clock);
    check("pre_reset_run", 6, {30'd0, valve_on, busy}, 32'b11);
    @(posedge Counter_clock);
    #2 Counter_rst_n = 1'b0;
    #1 check("async_reset", 0, 32'(outs[12:3]), 32'h0);
    @(negedge Counter_clock);
    check("reset_hold", 0, 32'(outs), 32'h0);
    Counter_rst_n = 1'b1;
    @(negedge Counter_clock);
    check("post_reset_idle", 0, {30'd0, busy, done}, 32'b00);
    measure(2'd0, 0, 0, d, en, dn, bh);
    check("post_reset_done_cycle", 0, 32'(d), 32'd14);
    check("post_reset_en_count", 0, 32'(en), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
